pll_lock_supervisor: RTL

PLL_LOCK_SUPERVISOR -- requirements
Module: pll_lock_supervisor

---
 rtl/pll_lock_supervisor.sv | 160 ++++++++++++++++
 1 files changed

// File: rtl/pll_lock_supervisor.sv
// PLL lock supervisor: sequences the PLL reset, waits for lock with a timeout
// and retry budget, and holds the downstream core in reset until lock has
// been stable for a programmable time.
module pll_lock_supervisor #(
  parameter int unsigned RST_PULSE_CYCLES    = 16,
  parameter int unsigned LOCK_TIMEOUT_CYCLES = 742500,
  parameter int unsigned LOCK_STABLE_CYCLES  = 7425,
  parameter int unsigned MAX_RETRIES         = 7
) (
  input  logic       clk_74a,
  input  logic       reset_n,
  input  logic       pll_locked,
  input  logic       relock_req,
  output logic       pll_rst,
  output logic       core_reset_n,
  output logic       lock_lost,
  output logic [3:0] retry_count,
  output logic       fault
);

  // The shared counter must reach the largest terminal count of any state
  localparam int unsigned CNT_MAX_A = (RST_PULSE_CYCLES > LOCK_TIMEOUT_CYCLES) ?
                                      RST_PULSE_CYCLES : LOCK_TIMEOUT_CYCLES;
  localparam int unsigned CNT_MAX   = (CNT_MAX_A > LOCK_STABLE_CYCLES) ?
                                      CNT_MAX_A : LOCK_STABLE_CYCLES;
  localparam int unsigned CNT_W     = $clog2(CNT_MAX + 1);
  localparam int unsigned RTY_W     = 4;

  localparam logic [CNT_W-1:0] RST_LAST  = CNT_W'(RST_PULSE_CYCLES - 1);
  localparam logic [CNT_W-1:0] TO_LAST   = CNT_W'(LOCK_TIMEOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0] STB_LAST  = CNT_W'(LOCK_STABLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_SAT   = CNT_W'(CNT_MAX);
  localparam logic [RTY_W-1:0] RTY_LIMIT = RTY_W'(MAX_RETRIES);
  localparam logic [RTY_W-1:0] RTY_SAT   = RTY_W'(15);

  localparam logic [2:0] ST_PLL_RESET = 3'd0;
  localparam logic [2:0] ST_WAIT_LOCK = 3'd1;
  localparam logic [2:0] ST_STABILIZE = 3'd2;
  localparam logic [2:0] ST_RUN       = 3'd3;
  localparam logic [2:0] ST_FAULT     = 3'd4;

  logic             sync1_q;
  logic             sync2_q;
  logic             locked_s;

  logic [2:0]       state_q,        state_d;
  logic [CNT_W-1:0] cnt_q,          cnt_d;
  logic [RTY_W-1:0] retry_q,        retry_d;
  logic             pll_rst_q,      pll_rst_d;
  logic             core_reset_n_q, core_reset_n_d;
  logic             lock_lost_q,    lock_lost_d;
  logic             fault_q,        fault_d;
  logic             restart;

  assign locked_s = sync2_q;

  // Two-flop synchronizer for the asynchronous PLL lock flag
  always_ff @(posedge clk_74a) begin
    if (!reset_n) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
    end else begin
      sync1_q <= pll_locked;
      sync2_q <= sync1_q;
    end
  end

  // Next-state, counter, retry and Moore output decode
  always_comb begin
    state_d     = state_q;
    retry_d     = retry_q;
    lock_lost_d = 1'b0;
    restart     = 1'b0;

    if (relock_req) begin
      // A relock also restarts a reset pulse already in progress
      state_d = ST_PLL_RESET;
      retry_d = '0;
      restart = 1'b1;
    end else begin
      case (state_q)
        ST_PLL_RESET: begin
          if (cnt_q == RST_LAST) state_d = ST_WAIT_LOCK;
        end
        ST_WAIT_LOCK: begin
          if (locked_s) begin
            state_d = ST_STABILIZE;
          end else if (cnt_q == TO_LAST) begin
            if (retry_q == RTY_LIMIT) begin
              state_d = ST_FAULT;
            end else begin
              state_d = ST_PLL_RESET;
              retry_d = (retry_q == RTY_SAT) ? retry_q : retry_q + RTY_W'(1);
            end
          end
        end
        ST_STABILIZE: begin
          if (!locked_s) begin
            state_d = ST_WAIT_LOCK;
          end else if (cnt_q == STB_LAST) begin
            state_d = ST_RUN;
            retry_d = '0;
          end
        end
        ST_RUN: begin
          if (!locked_s) begin
            state_d     = ST_PLL_RESET;
            lock_lost_d = 1'b1;
          end
        end
        ST_FAULT: begin
          state_d = ST_FAULT;
        end
        default: begin
          state_d = ST_PLL_RESET;
        end
      endcase
    end

    if (restart || (state_d != state_q)) begin
      cnt_d = '0;
    end else if (cnt_q == CNT_SAT) begin
      cnt_d = cnt_q;
    end else begin
      cnt_d = cnt_q + CNT_W'(1);
    end

    pll_rst_d      = (state_d == ST_PLL_RESET);
    core_reset_n_d = (state_d == ST_RUN);
    fault_d        = (state_d == ST_FAULT);
  end

  // State, counter and registered outputs
  always_ff @(posedge clk_74a) begin
    if (!reset_n) begin
      state_q        <= ST_PLL_RESET;
      cnt_q          <= '0;
      retry_q        <= '0;
      pll_rst_q      <= 1'b1;
      core_reset_n_q <= 1'b0;
      lock_lost_q    <= 1'b0;
      fault_q        <= 1'b0;
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      retry_q        <= retry_d;
      pll_rst_q      <= pll_rst_d;
      core_reset_n_q <= core_reset_n_d;
      lock_lost_q    <= lock_lost_d;
      fault_q        <= fault_d;
    end
  end

  assign pll_rst      = pll_rst_q;
  assign core_reset_n = core_reset_n_q;
  assign lock_lost    = lock_lost_q;
  assign retry_count  = retry_q;
  assign fault        = fault_q;

endmodule
